// File: rtl/jtag_pkg.sv
// Shared encodings for the JTAG host sequencer:
// states, opcodes and LSB-first TMS walks.
package jtag_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_INIT  = 3'd0;
  localparam state_t ST_IDLE  = 3'd1;
  localparam state_t ST_HDR   = 3'd2;
  localparam state_t ST_SHIFT = 3'd3;
  localparam state_t ST_TAIL  = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  typedef logic [1:0] op_t;
  localparam op_t OP_DR  = 2'd0;
  localparam op_t OP_IR  = 2'd1;
  localparam op_t OP_RST = 2'd2;
  localparam op_t OP_RSV = 2'd3;

  localparam logic [3:0] HDR_IR      = 4'b0011;
  localparam int         HDR_IR_LEN  = 4;
  localparam logic [2:0] HDR_DR      = 3'b001;
  localparam int         HDR_DR_LEN  = 3;
  localparam logic [5:0] HDR_RST     = 6'b011111;
  localparam int         HDR_RST_LEN = 6;
  localparam logic [1:0] TAIL_TMS    = 2'b01;
  localparam int         TAIL_LEN    = 2;

  function automatic logic hdr_tms(
    input op_t        op,
    input logic [2:0] idx
  );
    logic [5:0] v;
    case (op)
      OP_IR:   v = {2'b00, HDR_IR};
      OP_DR:   v = {3'b000, HDR_DR};
      default: v = HDR_RST;
    endcase
    return v[idx];
  endfunction

  function automatic logic [2:0] hdr_last(
    input op_t op
  );
    case (op)
      OP_IR:   return 3'(HDR_IR_LEN - 1);
      OP_DR:   return 3'(HDR_DR_LEN - 1);
      default: return 3'(HDR_RST_LEN - 1);
    endcase
  endfunction

endpackage

// File: rtl/jtag_master_tck_gen.sv
// TCK divider: DIV clk cycles per half period,
// with strobes for the clk edge that raises/drops TCK.
module jtag_tck_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DIV) + 1;

  logic [CW-1:0] cnt;
  logic          at_edge;

  assign at_edge = run && (cnt == CW'(DIV - 1));
  assign rise    = at_edge && !tck;
  assign fall    = at_edge && tck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
    end else if (at_edge) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/jtag_master.sv
// JTAG host sequencer: word-level IR/DR/reset scans
// walked from Run-Test/Idle, TDO captured LSB first.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int DIV     = 2
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [$clog2(MAX_LEN):0]  cmd_len,
  input  logic [MAX_LEN-1:0]        cmd_data,
  output logic                      rsp_valid,
  output logic [MAX_LEN-1:0]        rsp_data,
  output logic                      TCK,
  output logic                      TMS,
  output logic                      TDI,
  input  logic                      TDO
);

  localparam int LW = $clog2(MAX_LEN) + 1;

  state_t             state;
  op_t                op_q;
  logic [2:0]         slot;
  logic [LW-1:0]      len_q;
  logic [LW-1:0]      rem;
  logic [LW-1:0]      len_c;
  logic [MAX_LEN-1:0] sd;
  logic [MAX_LEN-1:0] bitm;
  logic               run;
  logic               rise;
  logic               fall;

  assign cmd_ready = (state == ST_IDLE) ||
                     (state == ST_DONE);

  assign run = (state == ST_INIT)  ||
               (state == ST_HDR)   ||
               (state == ST_SHIFT) ||
               (state == ST_TAIL);

  always_comb begin
    len_c = cmd_len;
    if (cmd_len == '0)
      len_c = LW'(1);
    else if (cmd_len > LW'(MAX_LEN))
      len_c = LW'(MAX_LEN);
  end

  jtag_tck_gen #(
    .DIV (DIV)
  ) u_tck (
    .clk   (CLK),
    .rst_n (RST_N),
    .run   (run),
    .tck   (TCK),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_INIT;
      op_q      <= OP_DR;
      slot      <= '0;
      len_q     <= '0;
      rem       <= '0;
      sd        <= '0;
      bitm      <= '0;
      TMS       <= 1'b1;
      TDI       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_INIT: begin
          if (fall) begin
            if (slot == hdr_last(OP_RST)) begin
              state <= ST_IDLE;
              slot  <= '0;
            end else begin
              slot <= slot + 3'd1;
              TMS  <= hdr_tms(OP_RST, slot + 3'd1);
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          if (cmd_valid) begin
            state    <= ST_HDR;
            op_q     <= cmd_op;
            len_q    <= len_c;
            sd       <= cmd_data;
            bitm     <= MAX_LEN'(1);
            rsp_data <= '0;
            slot     <= '0;
            TMS      <= hdr_tms(cmd_op, 3'd0);
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HDR: begin
          if (fall) begin
            if (slot == hdr_last(op_q)) begin
              slot <= '0;
              // op 2 and 3 both decode as TAP reset
              if (op_q[1]) begin
                state     <= ST_DONE;
                rsp_valid <= 1'b1;
              end else begin
                state <= ST_SHIFT;
                rem   <= len_q - LW'(1);
                TMS   <= (len_q == LW'(1));
                TDI   <= sd[0];
              end
            end else begin
              slot <= slot + 3'd1;
              TMS  <= hdr_tms(op_q, slot + 3'd1);
            end
          end
        end
        ST_SHIFT: begin
          if (rise)
            rsp_data <= rsp_data |
                        (bitm & {MAX_LEN{TDO}});
          if (fall) begin
            if (rem == '0) begin
              state <= ST_TAIL;
              slot  <= '0;
              TMS   <= TAIL_TMS[0];
              TDI   <= 1'b0;
            end else begin
              rem  <= rem - LW'(1);
              TMS  <= (rem == LW'(1));
              TDI  <= sd[1];
              sd   <= sd >> 1;
              bitm <= bitm << 1;
            end
          end
        end
        ST_TAIL: begin
          if (fall) begin
            if (slot == 3'(TAIL_LEN - 1)) begin
              state     <= ST_DONE;
              slot      <= '0;
              rsp_valid <= 1'b1;
            end else begin
              slot <= slot + 3'd1;
              TMS  <= TAIL_TMS[1];
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_master.sv
// Randomized scoreboard bench for jtag_master with a
// behavioural TAP (4-bit IR, 1-bit BYPASS DR).
module tb_jtag_master;
  import jtag_pkg::*;

  localparam logic [3:0] IR_CAP = 4'b0101;
  localparam logic [3:0] IR_RST = 4'b1110;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        TCK, TMS, TDI;
  logic        TDO = 1'b0;

  always #5 CLK = ~CLK;

  jtag_master #(.MAX_LEN(32), .DIV(2)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .TCK       (TCK),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO)
  );

  // ---------------- TAP model ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
    SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR
  } tap_t;

  tap_t       tap = TLR;
  logic [3:0] ir = IR_RST;
  logic [3:0] ir_sr = 4'b0;
  logic       byp = 1'b0;

  function automatic tap_t tap_nxt(tap_t s, logic m);
    case (s)
      TLR:  return m ? TLR  : RTI;
      RTI:  return m ? SDR  : RTI;
      SDR:  return m ? SIR  : CDR;
      CDR:  return m ? E1DR : SHDR;
      SHDR: return m ? E1DR : SHDR;
      E1DR: return m ? UDR  : PDR;
      PDR:  return m ? E2DR : PDR;
      E2DR: return m ? UDR  : SHDR;
      UDR:  return m ? SDR  : RTI;
      SIR:  return m ? TLR  : CIR;
      CIR:  return m ? E1IR : SHIR;
      SHIR: return m ? E1IR : SHIR;
      E1IR: return m ? UIR  : PIR;
      PIR:  return m ? E2IR : PIR;
      E2IR: return m ? UIR  : SHIR;
      default: return m ? SDR : RTI;
    endcase
  endfunction

  always @(posedge TCK) begin
    case (tap)
      TLR:  ir <= IR_RST;
      CIR:  ir_sr <= IR_CAP;
      SHIR: ir_sr <= {TDI, ir_sr[3:1]};
      UIR:  ir <= ir_sr;
      CDR:  byp <= 1'b0;
      SHDR: byp <= TDI;
      default: ;
    endcase
    tap <= tap_nxt(tap, TMS);
  end

  always @(negedge TCK)
    TDO <= (tap == SHIR) ? ir_sr[0] :
           (tap == SHDR) ? byp : 1'b0;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rsp;
    int          per;
    bit          chk_ir;
    logic [3:0]  ir;
    int          gap;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    failures = 0;
  int    stall = 0;
  bit    end_req = 1'b0;

  function automatic item_t mk(
    logic [1:0] op, int len, logic [31:0] data, int gap
  );
    item_t it;
    int L, pre, k;
    logic [3:0] pb;
    L = (len == 0) ? 1 : (len > 32) ? 32 : len;
    it.rsp = '0; it.chk_ir = 0; it.ir = '0;
    it.gap = gap;
    if (op[1]) begin
      it.per = 6; it.chk_ir = 1; it.ir = IR_RST;
    end else begin
      pre = (op == OP_IR) ? 4 : 1;
      pb  = (op == OP_IR) ? IR_CAP : 4'b0;
      it.per = (op == OP_IR) ? L + 6 : L + 5;
      for (int i = 0; i < L; i++)
        it.rsp[i] = (i < pre) ? pb[i] : data[i-pre];
      if (op == OP_IR) begin
        it.chk_ir = 1;
        for (int j = 0; j < 4; j++) begin
          k = L + j;
          it.ir[j] = (k < 4) ? pb[k] : data[k-4];
        end
      end
    end
    return it;
  endfunction

  task automatic chk(
    string name, logic [63:0] act, logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    int    cyc, tck_cnt, init_cyc, last_rsp;
    bit    tck_prev, in_init, rst_seen;
    item_t it;
    cyc = 0; tck_cnt = 0; init_cyc = 0;
    last_rsp = 0; tck_prev = 0;
    in_init = 0; rst_seen = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!RST_N) begin
        if (!rst_seen) begin
          chk("rst_tck", TCK, 0);
          chk("rst_tms", TMS, 1);
          chk("rst_tdi", TDI, 0);
          chk("rst_ready", cmd_ready, 0);
          chk("rst_rspv", rsp_valid, 0);
          chk("rst_rspd", rsp_data, 0);
        end
        rst_seen = 1; in_init = 1;
        init_cyc = 0; tck_cnt = 0; tck_prev = 0;
        sb.delete();
      end else begin
        rst_seen = 0;
        if (TCK && !tck_prev) tck_cnt++;
        tck_prev = TCK;
        if (in_init) begin
          init_cyc++;
          if (cmd_ready) begin
            chk("init_lat", init_cyc, 24);
            chk("init_tck", tck_cnt, 6);
            chk("init_tap", tap, RTI);
            in_init = 0;
          end else if (init_cyc > 200) begin
            chk("init_timeout", init_cyc, 24);
            in_init = 0;
          end
        end
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
          end else begin
            it = sb.pop_front();
            chk("rsp_data", rsp_data, it.rsp);
            chk("tck_periods", tck_cnt, it.per);
            chk("rsp_ready", cmd_ready, 1);
            chk("tap_rti", tap, RTI);
            if (it.chk_ir) chk("tap_ir", ir, it.ir);
            if (it.gap != 0)
              chk("b2b_gap", cyc - last_rsp, it.gap);
          end
          last_rsp = cyc;
        end
        if (cmd_ready) tck_cnt = 0;
      end
      if (end_req || cyc > 50000) begin
        if (!end_req) chk("watchdog", cyc, 0);
        chk("pending", sb.size(), 0);
        chk("stall", stall, 0);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(
    input logic [1:0] op, input int len,
    input logic [31:0] data, input int gap,
    input bit hold
  );
    int n = 0;
    @(negedge CLK);
    while (!cmd_ready && n < 500) begin
      @(negedge CLK);
      n++;
    end
    if (!cmd_ready) begin
      stall++;
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = 6'(len);
    cmd_data  = data;
    sb.push_back(mk(op, len, data, gap));
    @(posedge CLK);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    @(negedge CLK);
    #1 RST_N = 1'b1;
  endtask

  initial begin : stim
    int w;
    logic [31:0] r;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    do_reset();
    send(OP_IR, 4, 32'h9, 0, 0);
    send(OP_DR, 8, 32'hA5, 0, 0);
    send(OP_DR, 0, 32'h1, 0, 0);
    r = $urandom;
    send(OP_DR, 40, r, 0, 0);
    send(OP_IR, 32, $urandom, 0, 0);
    send(OP_RST, 5, $urandom, 0, 0);
    send(OP_IR, 2, 32'h3, 0, 0);
    send(OP_RSV, 9, $urandom, 0, 0);
    send(OP_DR, 2, 32'h2, 0, 1);
    send(OP_DR, 2, 32'h1, 29, 0);
    for (int i = 0; i < 24; i++)
      send(2'($urandom_range(0, 3)),
           $urandom_range(0, 40), $urandom, 0, 0);
    send(OP_DR, 8, 32'h5A, 0, 0);
    repeat (21) @(posedge CLK);
    #1 RST_N = 1'b0;
    do_reset();
    send(OP_IR, 6, 32'h2D, 0, 0);
    send(OP_DR, 31, $urandom, 0, 0);
    w = 0;
    while (sb.size() != 0 && w < 2000) begin
      @(negedge CLK);
      w++;
    end
    repeat (3) @(negedge CLK);
    end_req = 1'b1;
  end

endmodule
